// File: rtl/ncl_pkg.sv
// ---------------------------------------------------------------------------
// ncl_pkg
// Shared definitions for the clocked NCL (dual-rail) memory-data demux.
//
// Contents:
//   state_t    - handshake state machine encoding (S_NULL, S_DATA, S_RTZ)
//   RAIL_NULL  - rail pair code for a spacer (no data)
//   RAIL_ILL   - rail pair code that can never be produced by a legal sender
//   rail_pair  - packs one true/false rail pair into a 2-bit code
// ---------------------------------------------------------------------------
package ncl_pkg;

   // Wavefront state of the demux.
   //   S_NULL : idle, waiting for a complete DATA wavefront on the input
   //   S_DATA : a word is latched and presented on one output channel
   //   S_RTZ  : output returned to NULL, waiting for the consumer to release
   typedef enum logic [1:0] {
      S_NULL = 2'd0,
      S_DATA = 2'd1,
      S_RTZ  = 2'd2
   } state_t;

   // Rail pair codes written as {true_rail, false_rail}.
   // 01 and 10 both mean DATA (value 0 and 1 respectively).
   localparam logic [1:0] RAIL_NULL = 2'b00;
   localparam logic [1:0] RAIL_ILL  = 2'b11;

   // Packs a single dual-rail bit into its two-bit code so comparisons
   // against RAIL_NULL / RAIL_ILL read naturally.
   function automatic logic [1:0] rail_pair(input logic rail_t, input logic rail_f);
      return {rail_t, rail_f};
   endfunction

endpackage : ncl_pkg

// File: rtl/ncl_completion.sv
// ---------------------------------------------------------------------------
// ncl_completion
// Completion detector over N dual-rail pairs. Classifies the whole word in
// one combinational pass so the state machine only has to look at three
// flags.
//
// Parameters:
//   N         - number of rail pairs examined
//
// Ports:
//   rail_t    in  N  true rails
//   rail_f    in  N  false rails
//   all_data  out 1  every pair is 01 or 10
//   all_null  out 1  every pair is 00
//   illegal   out 1  at least one pair is 11
// ---------------------------------------------------------------------------
module ncl_completion
   import ncl_pkg::*;
#(
   parameter int N = 9
) (
   input  logic [N-1:0] rail_t,
   input  logic [N-1:0] rail_f,
   output logic         all_data,
   output logic         all_null,
   output logic         illegal
);

   logic [N-1:0] pair_null;
   logic [N-1:0] pair_ill;
   logic [N-1:0] pair_data;

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_pair
         assign pair_null[gi] = (rail_pair(rail_t[gi], rail_f[gi]) == RAIL_NULL);
         assign pair_ill[gi]  = (rail_pair(rail_t[gi], rail_f[gi]) == RAIL_ILL);
         // A pair is DATA exactly when it is neither a spacer nor illegal.
         assign pair_data[gi] = ~pair_null[gi] & ~pair_ill[gi];
      end
   endgenerate

   assign all_data = &pair_data;
   assign all_null = &pair_null;
   assign illegal  = |pair_ill;

endmodule : ncl_completion

// File: rtl/ncl_mem_demux_sync.sv
// ---------------------------------------------------------------------------
// ncl_mem_demux_sync
// Clocked dual-rail demux between the memory read port and its consumers.
// A complete DATA word {sel, d} is latched and presented on output channel
// sel; the rest of the channels stay NULL. Four-phase handshakes run on both
// sides: in_ack tells upstream that DATA was taken (1) or that the NULL
// wavefront was taken (0); out_ack[ch] is the selected consumer's reply.
// With WIDTH=8, SEL_W=1: channel 1 = instruction, channel 0 = constant.
//
// Parameters:
//   WIDTH  - data bits per word (rail pairs)
//   SEL_W  - select bits; NCH = 2**SEL_W output channels
//   CNT_W  - width of the transfer counter
//
// Ports:
//   clk       in  1          rising-edge clock
//   rst       in  1          synchronous active-high reset
//   sel_t/f   in  SEL_W      dual-rail channel index
//   d_t/d_f   in  WIDTH      dual-rail data
//   in_ack    out 1          upstream acknowledge
//   out_t/f   out NCH*WIDTH  dual-rail outputs, channel c at [c*WIDTH +: WIDTH]
//   out_ack   in  NCH        per-channel consumer acknowledge
//   err       out 1          sticky flag, set by any 11 rail pair
//   xfer_cnt  out CNT_W      number of accepted DATA words, wrapping
// ---------------------------------------------------------------------------
module ncl_mem_demux_sync
   import ncl_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int SEL_W = 1,
   parameter int CNT_W = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [SEL_W-1:0]              sel_t,
   input  logic [SEL_W-1:0]              sel_f,
   input  logic [WIDTH-1:0]              d_t,
   input  logic [WIDTH-1:0]              d_f,
   output logic                          in_ack,
   output logic [(2**SEL_W)*WIDTH-1:0]   out_t,
   output logic [(2**SEL_W)*WIDTH-1:0]   out_f,
   input  logic [(2**SEL_W)-1:0]         out_ack,
   output logic                          err,
   output logic [CNT_W-1:0]              xfer_cnt
);

   localparam int NCH = 2**SEL_W;
   localparam int N   = SEL_W + WIDTH;

   // ------------------------------------------------------------------
   // Completion detection over the full input word {sel, d}
   // ------------------------------------------------------------------
   logic in_all_data;
   logic in_all_null;
   logic in_illegal;

   ncl_completion #(
      .N (N)
   ) u_completion (
      .rail_t   ({sel_t, d_t}),
      .rail_f   ({sel_f, d_f}),
      .all_data (in_all_data),
      .all_null (in_all_null),
      .illegal  (in_illegal)
   );

   // ------------------------------------------------------------------
   // State and datapath registers
   // ------------------------------------------------------------------
   state_t                 state_reg,  state_next;
   logic [SEL_W-1:0]       ch_reg,     ch_next;
   // Only the true rails are kept: a complete DATA word has f == ~t, so
   // the false rails are regenerated on the way out.
   logic [WIDTH-1:0]       data_reg,   data_next;
   logic [CNT_W-1:0]       cnt_reg,    cnt_next;
   logic                   err_reg,    err_next;
   logic                   in_ack_reg, in_ack_next;
   logic [NCH*WIDTH-1:0]   out_t_reg,  out_t_next;
   logic [NCH*WIDTH-1:0]   out_f_reg,  out_f_next;

   // Acknowledge of the channel currently owning the transfer; the other
   // channels' acknowledges have no effect.
   logic ack_sel;
   assign ack_sel = out_ack[ch_reg];

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      ch_next    = ch_reg;
      data_next  = data_reg;
      cnt_next   = cnt_reg;
      // An 11 pair is recorded whatever the state, and never cleared
      // except by reset.
      err_next   = err_reg | in_illegal;

      case (state_reg)
         S_NULL: begin
            // Partial DATA simply waits; an illegal word is never taken
            // (in_all_data is already false for it, the explicit term keeps
            // the intent obvious).
            if (in_all_data && !in_illegal) begin
               state_next = S_DATA;
               ch_next    = sel_t;
               data_next  = d_t;
               cnt_next   = cnt_reg + CNT_W'(1);
            end
         end
         S_DATA: begin
            // Hysteresis: any input other than a full NULL wavefront,
            // including new DATA or partial NULL, leaves the latched word
            // alone. An illegal word is not all-NULL by construction.
            if (ack_sel && in_all_null) begin
               state_next = S_RTZ;
            end
         end
         S_RTZ: begin
            // Upstream DATA arriving here is held off until S_NULL.
            if (!ack_sel) begin
               state_next = S_NULL;
            end
         end
         default: begin
            state_next = S_NULL;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Output decode, computed from the next state so that the outputs can
   // be registered without adding a cycle of latency.
   // ------------------------------------------------------------------
   logic [NCH-1:0] chan_active;

   genvar gi;
   generate
      for (gi = 0; gi < NCH; gi++) begin : g_chan
         assign chan_active[gi] = (state_next == S_DATA) && (ch_next == SEL_W'(gi));
         assign out_t_next[gi*WIDTH +: WIDTH] = chan_active[gi] ?  data_next : '0;
         assign out_f_next[gi*WIDTH +: WIDTH] = chan_active[gi] ? ~data_next : '0;
      end
   endgenerate

   assign in_ack_next = (state_next == S_DATA);

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         // Aborts any transfer in flight; the latched word is dropped.
         state_reg  <= S_NULL;
         ch_reg     <= '0;
         data_reg   <= '0;
         cnt_reg    <= '0;
         err_reg    <= 1'b0;
         in_ack_reg <= 1'b0;
         out_t_reg  <= '0;
         out_f_reg  <= '0;
      end else begin
         state_reg  <= state_next;
         ch_reg     <= ch_next;
         data_reg   <= data_next;
         cnt_reg    <= cnt_next;
         err_reg    <= err_next;
         in_ack_reg <= in_ack_next;
         out_t_reg  <= out_t_next;
         out_f_reg  <= out_f_next;
      end
   end

   assign in_ack   = in_ack_reg;
   assign out_t    = out_t_reg;
   assign out_f    = out_f_reg;
   assign err      = err_reg;
   assign xfer_cnt = cnt_reg;

endmodule : ncl_mem_demux_sync

// File: tb/tb_ncl_mem_demux_sync.sv
// ---------------------------------------------------------------------------
// tb_ncl_mem_demux_sync
// Two instances: the I/C configuration (WIDTH=8, SEL_W=1, CNT_W=16) and a
// four-channel configuration with a 2-bit counter (WIDTH=4, SEL_W=2,
// CNT_W=2). Expected values come from a transaction-level model: a word is
// "held" on its channel from acceptance until the cycle in which the input
// is NULL and that channel has acknowledged.
// ---------------------------------------------------------------------------
module tb_ncl_mem_demux_sync;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   // ---------------- instance A: WIDTH=8, SEL_W=1 ----------------
   logic [0:0]  a_sel_t, a_sel_f;
   logic [7:0]  a_d_t, a_d_f;
   logic        a_in_ack;
   logic [15:0] a_out_t, a_out_f;
   logic [1:0]  a_out_ack;
   logic        a_err;
   logic [15:0] a_cnt;

   ncl_mem_demux_sync #(.WIDTH(8), .SEL_W(1), .CNT_W(16)) u_a (
      .clk      (clk),
      .rst      (rst),
      .sel_t    (a_sel_t),
      .sel_f    (a_sel_f),
      .d_t      (a_d_t),
      .d_f      (a_d_f),
      .in_ack   (a_in_ack),
      .out_t    (a_out_t),
      .out_f    (a_out_f),
      .out_ack  (a_out_ack),
      .err      (a_err),
      .xfer_cnt (a_cnt)
   );

   // ---------------- instance B: WIDTH=4, SEL_W=2, CNT_W=2 ----------------
   logic [1:0]  b_sel_t, b_sel_f;
   logic [3:0]  b_d_t, b_d_f;
   logic        b_in_ack;
   logic [15:0] b_out_t, b_out_f;
   logic [3:0]  b_out_ack;
   logic        b_err;
   logic [1:0]  b_cnt;

   ncl_mem_demux_sync #(.WIDTH(4), .SEL_W(2), .CNT_W(2)) u_b (
      .clk      (clk),
      .rst      (rst),
      .sel_t    (b_sel_t),
      .sel_f    (b_sel_f),
      .d_t      (b_d_t),
      .d_f      (b_d_f),
      .in_ack   (b_in_ack),
      .out_t    (b_out_t),
      .out_f    (b_out_f),
      .out_ack  (b_out_ack),
      .err      (b_err),
      .xfer_cnt (b_cnt)
   );

   // ---------------- reference model state (instance A) ----------------
   bit         m_busy;
   int         m_ch;
   logic [7:0] m_word;
   int         m_cnt;
   bit         m_err;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_a(input string tag);
      logic [15:0] et, ef;
      logic [7:0]  nw;
      et = '0;
      ef = '0;
      nw = ~m_word;
      if (m_busy) begin
         et = 16'(m_word) << (m_ch * 8);
         ef = 16'(nw) << (m_ch * 8);
      end
      chk({tag, ".out_t"},  64'(a_out_t),  64'(et));
      chk({tag, ".out_f"},  64'(a_out_f),  64'(ef));
      chk({tag, ".in_ack"}, 64'(a_in_ack), 64'(m_busy));
      chk({tag, ".err"},    64'(a_err),    64'(m_err));
      chk({tag, ".cnt"},    64'(a_cnt),    64'(m_cnt % 65536));
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic put_a_data(input int ch, input logic [7:0] w);
      a_sel_t = ch[0];
      a_sel_f = ~ch[0];
      a_d_t   = w;
      a_d_f   = ~w;
   endtask

   task automatic put_a_null();
      a_sel_t = '0;
      a_sel_f = '0;
      a_d_t   = '0;
      a_d_f   = '0;
   endtask

   // Random d rails with no 11 pair (may contain NULL pairs).
   task automatic rand_rails(output logic [7:0] t, output logic [7:0] f);
      for (int k = 0; k < 8; k++) begin
         case ($urandom_range(0, 2))
            0:       begin t[k] = 1'b0; f[k] = 1'b0; end
            1:       begin t[k] = 1'b1; f[k] = 1'b0; end
            default: begin t[k] = 1'b0; f[k] = 1'b1; end
         endcase
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int         ch, other, order, ng, k;
      logic [7:0] w, gt, gf;
      logic [1:0] c2;
      logic [3:0] bw, nbw;

      rst = 1'b1;
      put_a_null();
      a_out_ack = '0;
      b_sel_t = '0; b_sel_f = '0; b_d_t = '0; b_d_f = '0; b_out_ack = '0;
      m_busy = 0; m_ch = 0; m_word = '0; m_cnt = 0; m_err = 0;

      // ---- reset state ----
      step();
      step();
      chk_a("reset");
      chk("reset.b_cnt", 64'(b_cnt), 64'(0));
      chk("reset.b_out_t", 64'(b_out_t), 64'(0));
      rst = 1'b0;

      // ---- basic route: sel=1, d=A5 ----
      put_a_data(1, 8'hA5);
      step();
      m_busy = 1; m_ch = 1; m_word = 8'hA5; m_cnt++;
      chk_a("route_a5");

      // ---- hysteresis: new DATA with ack high is ignored ----
      a_out_ack = 2'b10;
      a_d_t = 8'hFF; a_d_f = 8'h00;
      step();
      chk_a("hyst_new_data");
      // partial NULL: data rails NULL, select still DATA
      a_d_t = '0; a_d_f = '0;
      step();
      chk_a("hyst_partial_null");

      // ---- return to zero ----
      put_a_null();
      step();
      m_busy = 0;
      chk_a("rtz_null");
      // new DATA while consumer still acknowledges: held off
      put_a_data(0, 8'h3C);
      step();
      chk_a("rtz_hold");
      a_out_ack = 2'b00;
      step();
      chk_a("rtz_release");
      step();
      m_busy = 1; m_ch = 0; m_word = 8'h3C; m_cnt++;
      chk_a("route_3c");
      put_a_null();
      a_out_ack = 2'b01;
      step();
      m_busy = 0;
      chk_a("ret_3c");
      a_out_ack = 2'b00;
      step();
      chk_a("idle_3c");

      // ---- randomized transfers ----
      for (int i = 0; i < 30; i++) begin
         ch    = $urandom_range(0, 1);
         other = 1 - ch;
         w     = 8'($urandom);
         if ($urandom_range(0, 1) == 1) begin
            put_a_data(ch, w);
            k = $urandom_range(0, 7);
            a_d_t[k] = 1'b0;
            a_d_f[k] = 1'b0;
            step();
            chk_a("rnd_partial");
         end
         put_a_data(ch, w);
         step();
         m_busy = 1; m_ch = ch; m_word = w; m_cnt++;
         chk_a("rnd_accept");

         ng = $urandom_range(0, 2);
         for (int g = 0; g < ng; g++) begin
            rand_rails(gt, gf);
            k = $urandom_range(0, 1);
            a_sel_t = k[0];
            a_sel_f = ~k[0];
            a_d_t = gt;
            a_d_f = gf;
            a_out_ack = 2'($urandom_range(0, 3));
            step();
            chk_a("rnd_hold");
         end

         order = $urandom_range(0, 2);
         if (order == 0) begin
            a_out_ack = '0;
            a_out_ack[ch] = 1'b1;
            step();
            chk_a("rnd_ack_first");
            put_a_null();
            step();
            m_busy = 0;
            chk_a("rnd_ack_then_null");
         end else if (order == 1) begin
            put_a_null();
            a_out_ack = '0;
            a_out_ack[other] = 1'b1;
            step();
            chk_a("rnd_null_first");
            a_out_ack[ch] = 1'b1;
            step();
            m_busy = 0;
            chk_a("rnd_null_then_ack");
         end else begin
            put_a_null();
            a_out_ack = '0;
            a_out_ack[ch] = 1'b1;
            step();
            m_busy = 0;
            chk_a("rnd_simul");
         end
         a_out_ack = '0;
         step();
         chk_a("rnd_idle");
      end

      // ---- illegal code in S_NULL ----
      put_a_data(1, 8'h00);
      a_d_t[3] = 1'b1;
      a_d_f[3] = 1'b1;
      step();
      m_err = 1;
      chk_a("illegal");
      a_d_t[3] = 1'b0;
      a_d_f[3] = 1'b0;
      step();
      chk_a("partial_after_ill");
      put_a_null();
      step();
      chk_a("null_after_ill");

      // ---- reset mid-transfer ----
      put_a_data(1, 8'h5A);
      step();
      m_busy = 1; m_ch = 1; m_word = 8'h5A; m_cnt++;
      chk_a("pre_reset");
      rst = 1'b1;
      step();
      m_busy = 0; m_err = 0; m_cnt = 0;
      chk_a("mid_reset");
      put_a_null();
      step();
      rst = 1'b0;
      chk_a("post_reset");

      // ---- four channels, 2-bit counter wrap ----
      for (int i = 0; i < 4; i++) begin
         ch  = 3 - i;
         c2  = 2'(ch);
         bw  = 4'($urandom_range(0, 15));
         nbw = ~bw;
         b_sel_t = c2;
         b_sel_f = ~c2;
         b_d_t   = bw;
         b_d_f   = nbw;
         step();
         chk("b_route.out_t",  64'(b_out_t),  64'(16'(bw) << (ch * 4)));
         chk("b_route.out_f",  64'(b_out_f),  64'(16'(nbw) << (ch * 4)));
         chk("b_route.in_ack", 64'(b_in_ack), 64'(1));
         chk("b_route.cnt",    64'(b_cnt),    64'((i + 1) % 4));
         b_sel_t = '0; b_sel_f = '0; b_d_t = '0; b_d_f = '0;
         b_out_ack = '0;
         b_out_ack[ch] = 1'b1;
         step();
         chk("b_ret.out_t",  64'(b_out_t),  64'(0));
         chk("b_ret.in_ack", 64'(b_in_ack), 64'(0));
         b_out_ack = '0;
         step();
      end
      chk("b_err", 64'(b_err), 64'(0));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_ncl_mem_demux_sync
